// File: rtl/wb_uart_pkg.sv
// Shared constants, STATUS bit layout and state types for the Wishbone UART.
package wb_uart_pkg;

    // Register index, taken from adr[2:1]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    // STATUS bit positions
    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_BUSY      = 1;
    localparam int ST_RX_VALID     = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_RX_FRAME_ERR = 4;
    localparam int ST_TX_IRQ_EN    = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Divisor values below 2 are too short to centre-sample, so clamp them.
    function automatic logic [15:0] eff_divisor(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/if_wb.sv
// Wishbone B3 classic bus, 16-bit data, byte address.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;

    modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack);
    modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack);
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, start-bit qualification, bit sampling.
// Emits a one-cycle byte_done with the byte and stop-bit error flag.
module uart_rx
    import wb_uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic [15:0] div,
    output logic        byte_done,
    output logic [7:0]  rx_byte,
    output logic        stop_err
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] half;

    // (div+1)>>1 without needing a 17-bit intermediate
    assign half    = {1'b0, div[15:1]} + {15'd0, div[0]};
    assign rx_byte = shift_q;

    // Next-state logic: falling edge arms a half-bit wait, then full-bit sampling
    always_comb begin
        sync1_d   = rxd;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_err  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = half - 16'd1;
                end
            end
            RX_START: begin
                if (cnt_q == 16'd0) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = div;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = div;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == 16'd0) begin
                    byte_done = 1'b1;
                    stop_err  = ~sync2_q;
                    state_d   = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State and datapath registers; the line idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone slave UART (8N1): DATA/STATUS/DIVISOR registers, double-buffered
// transmitter, one-deep receive holding register with overrun/framing flags.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter logic [15:0] reset_divisor = 16'd433
) (
    input  logic clk,
    input  logic reset,
    if_wb.slave  wb,
    input  logic uart_rxd,
    output logic uart_txd,
    output logic irq
);

    logic        ack_q, ack_d;
    logic [15:0] dat_s_q, dat_s_d;
    logic [15:0] div_q, div_d;
    logic        tx_irq_en_q, tx_irq_en_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_hold_q, tx_hold_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        rx_frame_err_q, rx_frame_err_d;
    logic [7:0]  rx_data_q, rx_data_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_load;

    logic        bus_req, bus_wr, bus_rd;
    logic [1:0]  bus_sel;
    logic        tx_wr_accept, rd_data_clr, st_wr;
    logic [15:0] div_eff;
    logic [15:0] status_word;
    logic        unused_adr_bits;

    logic        rx_byte_done;
    logic [7:0]  rx_byte;
    logic        rx_stop_err;

    assign bus_req      = wb.cyc & wb.stb & ~ack_q;
    assign bus_sel      = wb.adr[2:1];
    assign bus_wr       = bus_req & wb.we;
    assign bus_rd       = bus_req & ~wb.we;
    assign tx_wr_accept = bus_wr & (bus_sel == REG_DATA) & ~tx_full_q;
    assign rd_data_clr  = bus_rd & (bus_sel == REG_DATA);
    assign st_wr        = bus_wr & (bus_sel == REG_STATUS);
    assign div_eff      = eff_divisor(div_q);
    assign unused_adr_bits = ^{wb.adr[15:3], wb.adr[0]};

    assign wb.ack   = ack_q;
    assign wb.dat_s = dat_s_q;
    assign uart_txd = txd_q;
    assign irq      = rx_valid_q | (tx_irq_en_q & ~tx_full_q);

    uart_rx u_rx (
        .clk       (clk),
        .reset     (reset),
        .rxd       (uart_rxd),
        .div       (div_eff),
        .byte_done (rx_byte_done),
        .rx_byte   (rx_byte),
        .stop_err  (rx_stop_err)
    );

    // STATUS word assembly
    always_comb begin
        status_word                  = 16'd0;
        status_word[ST_TX_FULL]      = tx_full_q;
        status_word[ST_TX_BUSY]      = (tx_state_q != TX_IDLE);
        status_word[ST_RX_VALID]     = rx_valid_q;
        status_word[ST_RX_OVERRUN]   = rx_overrun_q;
        status_word[ST_RX_FRAME_ERR] = rx_frame_err_q;
        status_word[ST_TX_IRQ_EN]    = tx_irq_en_q;
    end

    // Bus decode, read mux and register updates; hardware flag sets beat software clears
    always_comb begin
        ack_d          = bus_req;
        dat_s_d        = 16'd0;
        div_d          = div_q;
        tx_irq_en_d    = tx_irq_en_q;
        tx_hold_d      = tx_hold_q;
        rx_valid_d     = rx_valid_q;
        rx_overrun_d   = rx_overrun_q;
        rx_frame_err_d = rx_frame_err_q;
        rx_data_d      = rx_data_q;

        if (bus_rd) begin
            case (bus_sel)
                REG_DATA:    dat_s_d = {8'h00, rx_data_q};
                REG_STATUS:  dat_s_d = status_word;
                REG_DIVISOR: dat_s_d = div_q;
                default:     dat_s_d = 16'd0;
            endcase
        end
        if (bus_wr && bus_sel == REG_DIVISOR) begin
            div_d = wb.dat_m;
        end
        if (tx_wr_accept) begin
            tx_hold_d = wb.dat_m[7:0];
        end
        if (st_wr) begin
            tx_irq_en_d = wb.dat_m[ST_TX_IRQ_EN];
            if (wb.dat_m[ST_RX_OVERRUN])   rx_overrun_d   = 1'b0;
            if (wb.dat_m[ST_RX_FRAME_ERR]) rx_frame_err_d = 1'b0;
        end
        if (rd_data_clr) begin
            rx_valid_d = 1'b0;
        end
        if (rx_byte_done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_data_clr) rx_overrun_d   = 1'b1;
            if (rx_stop_err)                rx_frame_err_d = 1'b1;
        end
    end

    // TX state machine: start, 8 data bits LSB first, stop; chains frames with no idle bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (tx_full_q) begin
                    tx_load    = 1'b1;
                    tx_shift_d = tx_hold_q;
                    txd_d      = 1'b0;
                    tx_cnt_d   = div_eff;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = div_eff;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = div_eff;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    if (tx_full_q) begin
                        tx_load    = 1'b1;
                        tx_shift_d = tx_hold_q;
                        txd_d      = 1'b0;
                        tx_cnt_d   = div_eff;
                        tx_state_d = TX_START;
                    end else begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase

        // A write is only accepted when the holding register is empty, so it never
        // coincides with the shifter emptying it.
        tx_full_d = tx_full_q;
        if (tx_load)      tx_full_d = 1'b0;
        if (tx_wr_accept) tx_full_d = 1'b1;
    end

    // All registers; reset drops the line high immediately, aborting any frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q          <= 1'b0;
            dat_s_q        <= 16'd0;
            div_q          <= reset_divisor;
            tx_irq_en_q    <= 1'b0;
            tx_full_q      <= 1'b0;
            tx_hold_q      <= 8'd0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_data_q      <= 8'd0;
            tx_state_q     <= TX_IDLE;
            tx_cnt_q       <= 16'd0;
            tx_bit_q       <= 3'd0;
            tx_shift_q     <= 8'd0;
            txd_q          <= 1'b1;
        end else begin
            ack_q          <= ack_d;
            dat_s_q        <= dat_s_d;
            div_q          <= div_d;
            tx_irq_en_q    <= tx_irq_en_d;
            tx_full_q      <= tx_full_d;
            tx_hold_q      <= tx_hold_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_data_q      <= rx_data_d;
            tx_state_q     <= tx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_bit_q       <= tx_bit_d;
            tx_shift_q     <= tx_shift_d;
            txd_q          <= txd_d;
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Directed-plus-random bench for wb_uart: bus timing, TX waveform against a
// bit-level frame model, RX flags against a small register model.
module tb_wb_uart;

    localparam logic [15:0] A_DATA   = 16'h0000;
    localparam logic [15:0] A_STATUS = 16'h0002;
    localparam logic [15:0] A_DIV    = 16'h0004;
    localparam logic [15:0] A_REG3   = 16'h0006;
    localparam int          HIST_LEN = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rxd = 1'b1;
    logic uart_txd;
    logic irq;

    if_wb wb_if ();

    wb_uart #(.reset_divisor(16'd433)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb       (wb_if),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .irq      (irq)
    );

    // Clock and cycle index
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // TX line history, one sample per cycle taken on the falling edge
    logic txd_hist [0:HIST_LEN-1];
    always @(negedge clk) begin
        if (cyc_cnt < HIST_LEN) txd_hist[cyc_cnt] = uart_txd;
    end

    int total = 0;
    int bad   = 0;

    // Expected TX bytes, in transmission order
    logic [7:0] exp_q[$];

    // Receive-side register model
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_irq_en = 1'b0;

    function automatic logic [15:0] status_exp(input logic full, input logic busy);
        return {7'd0, m_irq_en, 3'd0, m_fe, m_ovr, m_valid, busy, full};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One bus access, started on a falling edge; returns the edge index that raised ack
    task automatic wb_xfer(input logic we_i, input logic [15:0] adr_i, input logic [15:0] dat_i,
                           output logic [15:0] dat_o, output int ack_at);
        int waited;
        waited = 0;
        wb_if.cyc   = 1'b1;
        wb_if.stb   = 1'b1;
        wb_if.we    = we_i;
        wb_if.adr   = adr_i;
        wb_if.dat_m = dat_i;
        do begin
            @(negedge clk);
            waited++;
        end while (wb_if.ack !== 1'b1 && waited < 8);
        chk("ack_latency", 32'(waited), 32'd1);
        dat_o  = wb_if.dat_s;
        ack_at = cyc_cnt;
        wb_if.cyc = 1'b0;
        wb_if.stb = 1'b0;
        wb_if.we  = 1'b0;
        @(negedge clk);
        chk("ack_single", 32'(wb_if.ack), 32'd0);
    endtask

    task automatic wb_write(input logic [15:0] adr_i, input logic [15:0] dat_i, output int ack_at);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr_i, dat_i, dummy, ack_at);
    endtask

    task automatic wb_read_chk(input string tag, input logic [15:0] adr_i, input logic [15:0] expv);
        logic [15:0] rd;
        int          e;
        wb_xfer(1'b0, adr_i, 16'd0, rd, e);
        chk(tag, 32'(rd), 32'(expv));
    endtask

    // Compare the recorded TX line against nbytes frames from exp_q starting at cycle start
    task automatic check_tx(input int start, input int bitlen, input int nbytes, input int tail_bits);
        int         c;
        int         last;
        logic [7:0] b;
        logic       eb;
        last = start + nbytes * 10 * bitlen + tail_bits * bitlen;
        while (cyc_cnt < last + 2) @(negedge clk);
        chk("tx_idle_before", 32'(txd_hist[start-1]), 32'd1);
        c = start;
        for (int f = 0; f < nbytes; f++) begin
            b = exp_q.pop_front();
            for (int k = 0; k < 10; k++) begin
                if (k == 0)      eb = 1'b0;
                else if (k == 9) eb = 1'b1;
                else             eb = b[k-1];
                for (int j = 0; j < bitlen; j++) begin
                    chk("tx_bit", 32'(txd_hist[c]), 32'(eb));
                    c++;
                end
            end
        end
        for (int j = 0; j < tail_bits * bitlen; j++) begin
            chk("tx_idle_after", 32'(txd_hist[c]), 32'd1);
            c++;
        end
    endtask

    // Drive one serial frame at 4 clocks per bit, then idle
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = fr[k];
            repeat (4) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic model_rx(input logic stop_bit);
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        if (!stop_bit) m_fe = 1'b1;
    endtask

    initial begin
        int         e;
        int         e1;
        int         d;
        logic [7:0] b1;
        logic [7:0] b2;

        wb_if.cyc   = 1'b0;
        wb_if.stb   = 1'b0;
        wb_if.we    = 1'b0;
        wb_if.adr   = 16'd0;
        wb_if.dat_m = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(wb_if.ack), 32'd0);
        chk("rst_dat_s", 32'(wb_if.dat_s), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        wb_read_chk("rst_status", A_STATUS, 16'h0000);
        wb_read_chk("rst_divisor", A_DIV, 16'd433);
        wb_read_chk("divisor_adr0_ignored", A_DIV | 16'h0001, 16'd433);
        wb_write(A_REG3, 16'hFFFF, e);
        wb_read_chk("reg3_reads_zero", A_REG3, 16'h0000);
        wb_read_chk("divisor_after_reg3_wr", A_DIV, 16'd433);

        // Single frame 0xA5 at 4 clocks per bit
        wb_write(A_DIV, 16'd3, e);
        wb_read_chk("divisor_rw", A_DIV, 16'd3);
        wb_write(A_DATA, 16'h00A5, e);
        exp_q.push_back(8'hA5);
        check_tx(e + 1, 4, 1, 2);

        // Back-to-back frames; third write lands while holding register is full
        wb_write(A_DATA, 16'h0055, e1);
        wb_write(A_DATA, 16'h000F, e);
        wb_read_chk("status_full_busy", A_STATUS, status_exp(1'b1, 1'b1));
        wb_write(A_DATA, 16'h0099, e);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        check_tx(e1 + 1, 4, 2, 3);
        wb_read_chk("status_tx_done", A_STATUS, status_exp(1'b0, 1'b0));

        // Divisor below 2 behaves as 2
        wb_write(A_DIV, 16'd1, e);
        b1 = 8'($urandom);
        wb_write(A_DATA, {8'h00, b1}, e);
        exp_q.push_back(b1);
        check_tx(e + 1, 3, 1, 1);

        // Random divisor
        d = $urandom_range(2, 6);
        wb_write(A_DIV, 16'(d), e);
        b1 = 8'($urandom);
        wb_write(A_DATA, {8'h00, b1}, e);
        exp_q.push_back(b1);
        check_tx(e + 1, d + 1, 1, 1);
        wb_write(A_DIV, 16'd3, e);

        // TX interrupt enable
        wb_write(A_STATUS, 16'h0100, e);
        m_irq_en = 1'b1;
        chk("irq_tx_empty", 32'(irq), 32'd1);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        wb_write(A_DATA, {8'h00, b1}, e1);
        wb_write(A_DATA, {8'h00, b2}, e);
        chk("irq_tx_full", 32'(irq), 32'd0);
        wb_read_chk("status_irq_en", A_STATUS, status_exp(1'b1, 1'b1));
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        check_tx(e1 + 1, 4, 2, 1);
        chk("irq_tx_drained", 32'(irq), 32'd1);
        wb_write(A_STATUS, 16'h0000, e);
        m_irq_en = 1'b0;
        chk("irq_disabled", 32'(irq), 32'd0);

        // RX 0x3C
        send_rx(8'h3C, 1'b1);
        model_rx(1'b1);
        chk("irq_rx_valid", 32'(irq), 32'(m_valid));
        wb_read_chk("status_rx_valid", A_STATUS, status_exp(1'b0, 1'b0));
        wb_read_chk("rx_data_3c", A_DATA, 16'h003C);
        m_valid = 1'b0;
        wb_read_chk("status_rx_cleared", A_STATUS, status_exp(1'b0, 1'b0));
        chk("irq_rx_cleared", 32'(irq), 32'd0);

        // Overrun: two frames, no read in between
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_rx(b1, 1'b1);
        model_rx(1'b1);
        send_rx(b2, 1'b1);
        model_rx(1'b1);
        wb_read_chk("status_overrun", A_STATUS, status_exp(1'b0, 1'b0));
        wb_write(A_STATUS, 16'h0008, e);
        m_ovr = 1'b0;
        wb_read_chk("status_ovr_cleared", A_STATUS, status_exp(1'b0, 1'b0));
        wb_read_chk("rx_data_second", A_DATA, {8'h00, b2});
        m_valid = 1'b0;

        // Framing error: byte still delivered
        b1 = 8'($urandom);
        send_rx(b1, 1'b0);
        model_rx(1'b0);
        wb_read_chk("status_frame_err", A_STATUS, status_exp(1'b0, 1'b0));
        wb_read_chk("rx_data_frame_err", A_DATA, {8'h00, b1});
        m_valid = 1'b0;
        wb_write(A_STATUS, 16'h0010, e);
        m_fe = 1'b0;
        wb_read_chk("status_fe_cleared", A_STATUS, status_exp(1'b0, 1'b0));

        // One-clock glitch must not produce a byte
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        wb_read_chk("status_after_glitch", A_STATUS, status_exp(1'b0, 1'b0));
        chk("irq_after_glitch", 32'(irq), 32'd0);

        // Receiver still works after the glitch
        b1 = 8'($urandom);
        send_rx(b1, 1'b1);
        model_rx(1'b1);
        wb_read_chk("status_after_recover", A_STATUS, status_exp(1'b0, 1'b0));
        wb_read_chk("rx_data_recover", A_DATA, {8'h00, b1});
        m_valid = 1'b0;

        // Reset in the middle of a frame of zero bits
        wb_write(A_DATA, 16'h0000, e);
        repeat (9) @(negedge clk);
        chk("tx_mid_frame_low", 32'(uart_txd), 32'd0);
        #2 reset = 1'b1;
        #1 chk("tx_async_reset_high", 32'(uart_txd), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_fe = 1'b0;
        m_irq_en = 1'b0;
        repeat (8) @(negedge clk);
        chk("tx_stays_idle_after_reset", 32'(uart_txd), 32'd1);
        wb_read_chk("divisor_after_reset", A_DIV, 16'd433);
        wb_read_chk("status_after_reset", A_STATUS, status_exp(1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
